// File: rtl/spi_sensor_reader.sv
// Read-only SPI master for a serial sensor: frames DATA_BITS bits MSB-first,
// presents the word with a one-cycle data_valid strobe, then waits GAP_CYCLES.
module spi_sensor_reader #(
  parameter int CLK_DIV    = 25,
  parameter int DATA_BITS  = 16,
  parameter int GAP_CYCLES = 12500000
) (
  input  logic                 clk_50,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic                 miso,
  output logic                 sck,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE, GAP} state_t;

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t               state, state_d;
  logic [15:0]          div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 pending;
  logic                 miso_m, miso_s;
  logic [DATA_BITS-1:0] shreg, shift_in;
  logic                 div_last, bit_last, frame_end;

  assign div_last  = (div_cnt == 16'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign frame_end = (state == SHIFT_LO) && div_last && bit_last;

  generate
    if (DATA_BITS == 1) begin : g_single
      assign shift_in = miso_s;
    end else begin : g_multi
      assign shift_in = {shreg[DATA_BITS-2:0], miso_s};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start || pending || auto_en) state_d = SETUP;
      SETUP:    if (div_last) state_d = SHIFT_HI;
      SHIFT_HI: if (div_last) state_d = SHIFT_LO;
      SHIFT_LO: if (div_last) state_d = bit_last ? DONE : SHIFT_HI;
      DONE:     state_d = GAP;
      GAP:      if (gap_cnt == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n       = !(state inside {SETUP, SHIFT_HI, SHIFT_LO});
    sck        = (state == SHIFT_HI);
    data_valid = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      shreg     <= '0;
      data      <= '0;
      frame_cnt <= '0;
    end else begin
      // The divider restarts on every phase change, so each phase lasts CLK_DIV cycles.
      if (state_d != state)
        div_cnt <= '0;
      else if (state inside {SETUP, SHIFT_HI, SHIFT_LO})
        div_cnt <= div_cnt + 16'd1;

      if (state == IDLE)
        bit_cnt <= '0;
      else if ((state == SHIFT_LO) && div_last && !bit_last)
        bit_cnt <= bit_cnt + BIT_W'(1);

      if (state == DONE)
        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      else if ((state == GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GAP_W'(1);

      if (state == IDLE) pending <= 1'b0;
      else if (start)    pending <= 1'b1;

      // Sample just before sck falls; the sensor changes data on the falling edge.
      if ((state == SHIFT_HI) && div_last)
        shreg <= shift_in;

      // Loaded on entry to DONE so data and frame_cnt are already current
      // while data_valid is high.
      if (frame_end) begin
        data      <= shreg;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_reader.sv
// Directed bench: sensor models drive MSB-first words; frame timing,
// request handling, reset abort, counter wrap and jittered MISO are checked.
module tb_spi_sensor_reader;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset_n;
  logic start_a, auto_a, miso_a, sck_a, cs_n_a, dv_a, busy_a;
  logic [15:0] data_a, cnt_a;
  logic start_b, auto_b, miso_b, sck_b, cs_n_b, dv_b, busy_b;
  logic [15:0] data_b, cnt_b;
  logic start_c, auto_c, miso_c, sck_c, cs_n_c, dv_c, busy_c;
  logic [0:0]  data_c;
  logic [15:0] cnt_c;

  spi_sensor_reader #(.CLK_DIV(4), .DATA_BITS(16), .GAP_CYCLES(20)) dut_a (
    .clk_50(clk), .reset_n(reset_n), .start(start_a), .auto_en(auto_a), .miso(miso_a),
    .sck(sck_a), .cs_n(cs_n_a), .data(data_a), .data_valid(dv_a), .busy(busy_a),
    .frame_cnt(cnt_a));

  spi_sensor_reader #(.CLK_DIV(3), .DATA_BITS(16), .GAP_CYCLES(1)) dut_b (
    .clk_50(clk), .reset_n(reset_n), .start(start_b), .auto_en(auto_b), .miso(miso_b),
    .sck(sck_b), .cs_n(cs_n_b), .data(data_b), .data_valid(dv_b), .busy(busy_b),
    .frame_cnt(cnt_b));

  spi_sensor_reader #(.CLK_DIV(3), .DATA_BITS(1), .GAP_CYCLES(1)) dut_c (
    .clk_50(clk), .reset_n(reset_n), .start(start_c), .auto_en(auto_c), .miso(miso_c),
    .sck(sck_c), .cs_n(cs_n_c), .data(data_c), .data_valid(dv_c), .busy(busy_c),
    .frame_cnt(cnt_c));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Sensor A: MSB on cs_n fall, next bit on each sck fall.
  logic [15:0] word_a = 16'h0;
  int idx_a = 0;
  always @(negedge cs_n_a) begin idx_a = 15; miso_a = word_a[15]; end
  always @(negedge sck_a) if (!cs_n_a && idx_a > 0) begin idx_a--; miso_a = word_a[idx_a]; end

  // Sensor B: same protocol with an output delay jittered across one clk period.
  logic [15:0] word_b = 16'h0;
  int idx_b = 0;
  always @(negedge cs_n_b) begin
    idx_b = 15;
    #($urandom_range(1, 19));
    miso_b = word_b[15];
  end
  always @(negedge sck_b) if (!cs_n_b && idx_b > 0) begin
    idx_b--;
    #($urandom_range(1, 19));
    miso_b = word_b[idx_b];
  end

  typedef struct {
    logic [15:0] miso_word;
    logic [15:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  // One start-triggered frame on A, with full timing checks.
  task automatic do_frame(input logic [15:0] w, input logic [15:0] exp_data,
                          input logic [15:0] exp_cnt, input string tag);
    int low = 0, rises = 0, valids = 0, hi_run = 0, bad_hi = 0;
    logic prev_sck = 1'b0;
    logic [15:0] got_data = 16'hx, got_cnt = 16'hx;
    bit seen = 0;
    word_a  = w;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!cs_n_a) low++;
      if (sck_a) hi_run++;
      else begin
        if (prev_sck && hi_run != 4) bad_hi++;
        hi_run = 0;
      end
      if (sck_a && !prev_sck) rises++;
      if (dv_a) begin valids++; got_data = data_a; got_cnt = cnt_a; seen = 1; end
      prev_sck = sck_a;
      if (seen && !busy_a) break;
      @(negedge clk);
    end
    check({tag, "/cs_low_cycles"}, low, 132);
    check({tag, "/sck_rises"}, rises, 16);
    check({tag, "/bad_hi_phases"}, bad_hi, 0);
    check({tag, "/valid_strobes"}, valids, 1);
    check({tag, "/data"}, got_data, exp_data);
    check({tag, "/frame_cnt"}, got_cnt, exp_cnt);
    check({tag, "/idle_at_end"}, busy_a, 1'b0);
    check({tag, "/data_held"}, data_a, exp_data);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int t1, t2, hi_gap, nvalid, falls, valids, rises, n, last_t;
    bit gap_counting, got_cs;
    logic prev_cs, prev_sck;
    logic [7:0] pat_c;

    vecs[0] = '{16'hA5C3, 16'hA5C3, 16'd1};
    vecs[1] = '{16'h0001, 16'h0001, 16'd2};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'd3};
    vecs[3] = '{16'h0000, 16'h0000, 16'd4};
    vecs[4] = '{16'h8001, 16'h8001, 16'd5};

    reset_n = 1'b0;
    {start_a, auto_a, miso_a} = 3'b000;
    {start_b, auto_b, miso_b} = 3'b000;
    {start_c, auto_c, miso_c} = 3'b000;
    repeat (3) @(negedge clk);
    check("rst/cs_n", cs_n_a, 1'b1);
    check("rst/sck", sck_a, 1'b0);
    check("rst/data", data_a, 16'h0);
    check("rst/data_valid", dv_a, 1'b0);
    check("rst/busy", busy_a, 1'b0);
    check("rst/frame_cnt", cnt_a, 16'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) do_frame(vecs[i].miso_word, vecs[i].exp_data, vecs[i].exp_cnt,
                               $sformatf("vec%0d", i));

    // Auto mode: two frames 154 cycles apart, 22 cycles of cs_n high between.
    word_a = 16'h0001;
    auto_a = 1'b1;
    t1 = -1; t2 = -1; hi_gap = 0; nvalid = 0; gap_counting = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (gap_counting) begin
        if (cs_n_a) hi_gap++;
        else gap_counting = 0;
      end
      if (dv_a) begin
        nvalid++;
        if (nvalid == 1) begin
          t1 = c;
          check("auto/data1", data_a, 16'h0001);
          check("auto/cnt1", cnt_a, 16'd6);
          word_a = 16'hFFFF;
          gap_counting = 1;
          hi_gap = 1;
        end else begin
          t2 = c;
          check("auto/data2", data_a, 16'hFFFF);
          check("auto/cnt2", cnt_a, 16'd7);
          word_a = 16'h1234;
          break;
        end
      end
    end
    check("auto/valid_count", nvalid, 2);
    check("auto/spacing", t2 - t1, 154);
    check("auto/cs_high_between", hi_gap, 22);

    // Dropping auto_en mid-frame finishes that frame, then the block idles.
    got_cs = 0;
    for (int c = 0; c < 100 && !got_cs; c++) begin @(negedge clk); got_cs = !cs_n_a; end
    check("auto_off/frame3_started", got_cs, 1'b1);
    repeat (20) @(negedge clk);
    auto_a = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 400 && nvalid == 0; c++) begin
      @(negedge clk);
      if (dv_a) begin
        nvalid++;
        check("auto_off/data3", data_a, 16'h1234);
        check("auto_off/cnt3", cnt_a, 16'd8);
      end
    end
    check("auto_off/valid_seen", nvalid, 1);
    falls = 0;
    for (int c = 0; c < 300; c++) begin @(negedge clk); if (!cs_n_a) falls++; end
    check("auto_off/no_more_frames", falls, 0);
    check("auto_off/idle", busy_a, 1'b0);

    // Three starts during a frame -> exactly one extra frame, right after GAP.
    word_a = 16'h3C3C;
    prev_cs = 1'b1; falls = 0; valids = 0; hi_gap = 0; gap_counting = 0;
    for (int c = 0; c < 700; c++) begin
      start_a = (c == 0 || c == 10 || c == 30 || c == 60);
      @(negedge clk);
      if (prev_cs && !cs_n_a) falls++;
      if (gap_counting) begin
        if (cs_n_a) hi_gap++;
        else gap_counting = 0;
      end
      if (dv_a) begin
        valids++;
        check($sformatf("pend/data%0d", valids), data_a, 16'h3C3C);
        if (valids == 1) begin gap_counting = 1; hi_gap = 1; end
      end
      prev_cs = cs_n_a;
    end
    start_a = 1'b0;
    check("pend/frames", falls, 2);
    check("pend/valids", valids, 2);
    check("pend/cs_high_between", hi_gap, 22);
    check("pend/frame_cnt", cnt_a, 16'd10);

    // start together with auto_en for one cycle -> a single frame.
    start_a = 1'b1; auto_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; auto_a = 1'b0;
    prev_cs = cs_n_a; falls = 1; valids = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_cs && !cs_n_a) falls++;
      if (dv_a) valids++;
      prev_cs = cs_n_a;
    end
    check("both/frames", falls, 1);
    check("both/valids", valids, 1);
    check("both/frame_cnt", cnt_a, 16'd11);

    // Reset at bit 7 aborts cleanly.
    word_a = 16'hFFFF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rises = 0; prev_sck = 1'b0;
    for (int c = 0; c < 200 && rises < 7; c++) begin
      @(negedge clk);
      if (sck_a && !prev_sck) rises++;
      prev_sck = sck_a;
    end
    check("rst_mid/reached_bit7", rises, 7);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid/cs_n", cs_n_a, 1'b1);
    check("rst_mid/sck", sck_a, 1'b0);
    check("rst_mid/data", data_a, 16'h0);
    check("rst_mid/busy", busy_a, 1'b0);
    check("rst_mid/data_valid", dv_a, 1'b0);
    check("rst_mid/frame_cnt", cnt_a, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_frame(16'hC0DE, 16'hC0DE, 16'd1, "after_rst");

    // frame_cnt wrap.
    force dut_a.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_cnt;
    @(negedge clk);
    do_frame(16'h6E21, 16'h6E21, 16'h0000, "wrap");

    // CLK_DIV=3, jittered MISO, random words.
    word_b = 16'($urandom);
    auto_b = 1'b1;
    n = 0;
    for (int c = 0; c < 400 * 110 && n < 400; c++) begin
      @(negedge clk);
      if (dv_b) begin
        check($sformatf("jit/frame%0d", n), data_b, word_b);
        word_b = 16'($urandom);
        n++;
      end
    end
    auto_b = 1'b0;
    check("jit/frames_done", n, 400);
    check("jit/frame_cnt", cnt_b, 16'd400);

    // DATA_BITS=1, minimum gap: 12-cycle frame period.
    pat_c = 8'b1011_0010;
    miso_c = pat_c[0];
    auto_c = 1'b1;
    n = 0; last_t = -1;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (dv_c) begin
        check($sformatf("one_bit/data%0d", n), data_c, pat_c[n]);
        if (last_t >= 0) check($sformatf("one_bit/spacing%0d", n), c - last_t, 12);
        last_t = c;
        n++;
        if (n < 8) miso_c = pat_c[n];
      end
    end
    auto_c = 1'b0;
    check("one_bit/frames_done", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
